// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: counts div_reg system clocks per tick, toggles clk_out on every tick,
// and runs either periodically or as a single one-shot tick.
module clk_div_ctrl #(
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             clk_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  // state | meaning
  // IDLE  | waiting for start; configuration accepted here only
  // RUN   | counting toward div_reg-1
  // DONE  | one-shot tick just fired; done pulses on the way back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] div_reg, div_nx, cnt_nx;
  logic             mode_reg, mode_nx;
  logic             tick_nx, clk_out_nx, done_nx;
  logic             handshake, terminal;

  assign handshake = cfg_valid && cfg_ready;
  assign terminal  = (cnt == div_reg - CNT_W'(1));

  always_comb begin
    state_nx   = state;
    div_nx     = div_reg;
    mode_nx    = mode_reg;
    cnt_nx     = cnt;
    tick_nx    = 1'b0;
    clk_out_nx = clk_out;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          // a zero divide would never reach terminal count; treat it as divide-by-one
          div_nx  = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
          mode_nx = cfg_oneshot;
        end
        if (start) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (terminal) begin
          cnt_nx     = '0;
          tick_nx    = 1'b1;
          clk_out_nx = ~clk_out;
          if (mode_reg) state_nx = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tick      <= 1'b0;
      clk_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
      div_reg   <= CNT_W'(DEFAULT_DIV);
      mode_reg  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tick      <= tick_nx;
      clk_out   <= clk_out_nx;
      busy      <= (state_nx == RUN);
      done      <= done_nx;
      cfg_ready <= (state_nx == IDLE);
      div_reg   <= div_nx;
      mode_reg  <= mode_nx;
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 26, width of divide value and counter.
REQ-002 Parameter DEFAULT_DIV, default 50000000, divide value loaded at reset.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_valid  input  1  new divide value offered on cfg_div.
REQ-006 cfg_div  input  CNT_W  requested divide value, in clk cycles per tick.
REQ-007 cfg_oneshot  input  1  mode captured with cfg_div: 1 = single tick then stop, 0 = periodic.
REQ-008 cfg_ready  output  1  controller accepts configuration this cycle.
REQ-009 start  input  1  one-cycle request to begin counting.
REQ-010 stop  input  1  one-cycle request to abort counting.
REQ-011 tick  output  1  one-cycle pulse at each terminal count.
REQ-012 clk_out  output  1  slow square wave, toggles on every tick.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse after the one-shot tick completes.
REQ-015 cnt  output  CNT_W  current counter value.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-017 cfg_ready SHALL be 1 only in IDLE; a handshake occurs when cfg_valid and cfg_ready are both 1 on an edge.
REQ-018 On a handshake, div_reg SHALL take cfg_div and mode_reg SHALL take cfg_oneshot; a cfg_div of 0 SHALL be stored as 1.
REQ-019 cfg_valid outside IDLE SHALL be ignored, leaving div_reg and mode_reg unchanged.
REQ-020 IDLE -> RUN on start; cnt SHALL be 0 and busy SHALL be 1 in the first RUN cycle.
REQ-021 If start and a cfg handshake happen on the same edge, both SHALL take effect, and the run SHALL use the new div_reg/mode_reg.
REQ-022 In RUN, cnt SHALL increment by 1 per cycle while cnt != div_reg-1.
REQ-023 In RUN with cnt == div_reg-1, the next edge SHALL set cnt to 0, pulse tick for one cycle and toggle clk_out; the tick period is div_reg cycles.
REQ-024 div_reg == 1 SHALL give tick every cycle and make clk_out toggle every cycle.
REQ-025 Periodic mode: the FSM SHALL stay in RUN after a tick.
REQ-026 One-shot mode: the terminal-count edge SHALL move the FSM to DONE and pulse tick; the following edge SHALL move it to IDLE with done=1 for that one DONE cycle.
REQ-027 stop in RUN SHALL move the FSM to IDLE on the next edge and clear cnt to 0, with no tick, no done, and clk_out held.
REQ-028 stop coinciding with terminal count SHALL win, suppressing the tick and the clk_out toggle.
REQ-029 start in RUN or DONE SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-030 cnt SHALL hold its value in IDLE and DONE (0 after stop or terminal count).
REQ-031 Counter arithmetic SHALL be CNT_W-bit unsigned; cnt never exceeds div_reg-1, so it never wraps.

Reset
REQ-032 With rst=1 on an edge, the next state SHALL be: state=IDLE, cnt=0, tick=0, clk_out=0, busy=0, done=0, div_reg=DEFAULT_DIV, mode_reg=0 (periodic).
REQ-033 rst SHALL take priority over start, stop and cfg_valid in the same cycle.
REQ-034 rst asserted mid-RUN SHALL abort with no tick or done pulse, and the outputs SHALL follow REQ-032.
REQ-035 After rst deasserts, cfg_ready SHALL be 1 in the first cycle.

Verification
REQ-036 Periodic run: cfg_div=4, oneshot=0, then start -> tick every 4 cycles, clk_out period 8 cycles, busy=1, cnt sequence 0,1,2,3,0.
REQ-037 One-shot run: cfg_div=3, oneshot=1, then start -> exactly one tick 3 cycles after RUN entry, done=1 on the next cycle, then IDLE with busy=0.
REQ-038 Zero divide: cfg_div=0 with start on the same edge -> div_reg=1, tick every cycle, clk_out toggles every cycle.
REQ-039 Stop on terminal count: cfg_div=5, stop asserted when cnt=4 -> no tick, clk_out unchanged, IDLE with cnt=0.
REQ-040 Config while running: cfg_valid with cfg_div=2 during RUN (div 6) -> cfg_ready=0, tick period stays 6; after stop, the new cfg is accepted.
REQ-041 Reset mid-run: rst when cnt=2 with clk_out=1 -> next cycle clk_out=0, cnt=0, div_reg=50000000, cfg_ready=1.
